// File: rtl/pci_arbiter_if.sv
// pci_arbiter_if: request/grant lines and bus-monitor taps shared by the arbiter and its initiators.
// The master modport is the arbiter side; the slave modport is the initiator/bus side.
interface pci_arbiter_if #(parameter int NREQ = 4) ();
    localparam int OW = $clog2(NREQ);
    logic [NREQ-1:0] req_n;
    logic            frame_n;
    logic            irdy_n;
    logic [NREQ-1:0] gnt_n;
    logic [OW-1:0]   owner;
    logic            bus_idle;
    modport master (input req_n, frame_n, irdy_n, output gnt_n, owner, bus_idle);
    modport slave (output req_n, frame_n, irdy_n, input gnt_n, owner, bus_idle);
endinterface

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI central arbiter with hidden arbitration, parking and grant timeout.
// All outputs are registered; gnt_n reflects the state of the previous cycle.
module pci_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    parameter int PARK    = 0
) (
    input logic           clk,
    input logic           rst_n,
    pci_arbiter_if.master bus
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = 8;

    typedef enum logic [1:0] {GAP, GRANT, BUSY} state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   owner_q, owner_nx, winner;
    logic [TW-1:0]   timer, timer_nx;
    logic [NREQ-1:0] req, gnt_q, gnt_nx;
    logic            bus_idle_q, start, other, timed_out;

    assign req       = ~bus.req_n;
    assign start     = ~bus.frame_n & bus_idle_q;
    assign other     = |(req & ~(NREQ'(1) << owner_q));
    assign timed_out = timer == TW'(TIMEOUT - 1);

    // Search downward so the closest requester after the owner overrides farther ones.
    always_comb begin
        winner = owner_q;
        for (int i = NREQ - 1; i > 0; i--)
            if (req[(int'(owner_q) + i) % NREQ]) winner = OW'((int'(owner_q) + i) % NREQ);
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner_q;
        timer_nx = timer;
        case (state)
            GAP: begin
                state_nx = GRANT;
                owner_nx = winner;
                timer_nx = '0;
            end
            GRANT: begin
                if (start)
                    state_nx = BUSY;
                else if (other && (!req[owner_q] || timed_out))
                    state_nx = GAP;
                else if (bus_idle_q && other && !timed_out)
                    timer_nx = timer + 1'b1;
            end
            BUSY: begin
                if (other)
                    state_nx = GAP;
                else if (bus.frame_n && bus.irdy_n) begin
                    state_nx = GRANT;
                    timer_nx = '0;
                end
            end
            default: state_nx = GAP;
        endcase
    end

    always_comb begin
        gnt_nx = '1;
        if (state == GRANT || (state == BUSY && !other)) gnt_nx[owner_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GAP;
            owner_q    <= OW'(PARK);
            timer      <= '0;
            gnt_q      <= '1;
            bus_idle_q <= 1'b1;
        end else begin
            state      <= state_nx;
            owner_q    <= owner_nx;
            timer      <= timer_nx;
            gnt_q      <= gnt_nx;
            bus_idle_q <= bus.frame_n & bus.irdy_n;
        end
    end

    assign bus.gnt_n    = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.bus_idle = bus_idle_q;

    // Grants are exclusive and never hand over without an all-high cycle in between.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~gnt_q));
    a_gap: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_q != '1 && $past(gnt_q) != '1) |-> gnt_q == $past(gnt_q));
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_pci_arbiter;
    localparam int NREQ = 4;
    localparam int TIMEOUT = 16;
    localparam int PARK = 0;

    logic clk = 0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    bit live = 0;

    pci_arbiter_if #(.NREQ(NREQ)) ifc ();
    pci_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .PARK(PARK)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int pick(input int own, input logic [3:0] rq);
        for (int i = 1; i < NREQ; i++)
            if (rq[(own + i) % NREQ]) return (own + i) % NREQ;
        return own;
    endfunction

    // Model: who holds the bus (none during a gap), whether their transaction is running,
    // how many idle cycles they have kept others waiting, and the outputs one cycle behind.
    bit m_gap, m_txn, m_idle;
    int m_owner, m_cnt;
    logic [3:0] m_gnt;

    always @(posedge clk) begin
        logic [3:0] rq;
        bit oth;
        rq = ~ifc.req_n;
        if (!rst_n) begin
            m_gap = 1; m_txn = 0; m_owner = PARK; m_cnt = 0; m_idle = 1; m_gnt = 4'hF;
        end else begin
            oth = (rq & ~(4'b0001 << m_owner)) != 0;
            m_gnt = (m_gap || (m_txn && oth)) ? 4'hF : ~(4'b0001 << m_owner);
            if (m_gap) begin
                m_owner = pick(m_owner, rq); m_gap = 0; m_txn = 0; m_cnt = 0;
            end else if (!m_txn) begin
                if (!ifc.frame_n && m_idle) m_txn = 1;
                else if (oth && (!rq[m_owner] || m_cnt == TIMEOUT - 1)) m_gap = 1;
                else if (m_idle && oth) m_cnt++;
            end else if (oth) m_gap = 1;
            else if (ifc.frame_n && ifc.irdy_n) begin
                m_txn = 0; m_cnt = 0;
            end
            m_idle = ifc.frame_n & ifc.irdy_n;
        end
        live = 1;
    end

    always @(negedge clk) if (live) begin
        chk("model_gnt", ifc.gnt_n, m_gnt);
        chk("model_owner", ifc.owner, m_owner);
        chk("model_idle", ifc.bus_idle, m_idle);
        chk("onehot", $countones(~ifc.gnt_n) <= 1, 1);
    end

    task automatic do_reset();
        rst_n = 0; ifc.req_n = 4'hF; ifc.frame_n = 1; ifc.irdy_n = 1;
        tick(2);
        rst_n = 1;
        tick(3);
    endtask

    initial begin
        int exp_rr[6];
        int found;
        int txn_left;
        rst_n = 0; ifc.req_n = 4'hF; ifc.frame_n = 1; ifc.irdy_n = 1;
        tick(3);
        chk("rst_gnt", ifc.gnt_n, 4'hF);
        chk("rst_owner", ifc.owner, 0);
        chk("rst_idle", ifc.bus_idle, 1);
        rst_n = 1;
        tick(1);
        chk("gap_gnt", ifc.gnt_n, 4'hF);
        tick(1);
        chk("park_gnt", ifc.gnt_n, 4'b1110);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("park_hold", {ifc.owner, ifc.gnt_n}, {2'd0, 4'b1110});
        end

        ifc.req_n = 4'b1011;
        tick(2);
        chk("single_gap", ifc.gnt_n, 4'hF);
        tick(1);
        chk("single_gnt", ifc.gnt_n, 4'b1011);
        chk("single_owner", ifc.owner, 2);

        do_reset();
        ifc.req_n = 4'b0000;
        exp_rr = '{0, 1, 2, 3, 0, 1};
        for (int t = 0; t < 6; t++) begin
            found = -1;
            for (int w = 0; w < 40 && found < 0; w++) begin
                for (int b = 0; b < NREQ; b++) if (!ifc.gnt_n[b]) found = b;
                if (found < 0) tick(1);
            end
            chk("rr_owner", found, exp_rr[t]);
            if (found < 0) break;
            ifc.frame_n = 0; ifc.irdy_n = 0; tick(2);
            ifc.frame_n = 1; tick(1);
            ifc.irdy_n = 1; tick(1);
        end
        ifc.req_n = 4'hF;

        do_reset();
        ifc.req_n = 4'b1101;
        tick(3);
        chk("to_owner_gnt", ifc.gnt_n, 4'b1101);
        ifc.req_n = 4'b1001;
        tick(16);
        chk("to_hold", ifc.gnt_n, 4'b1101);
        tick(1);
        chk("to_release", ifc.gnt_n, 4'hF);
        tick(1);
        chk("to_next", {ifc.owner, ifc.gnt_n}, {2'd2, 4'b1011});

        do_reset();
        ifc.req_n = 4'hF;
        ifc.frame_n = 0; ifc.irdy_n = 0;
        tick(1);
        ifc.req_n = 4'b0111;
        tick(1);
        chk("hid_gap", ifc.gnt_n, 4'hF);
        tick(2);
        chk("hid_gnt", {ifc.owner, ifc.gnt_n}, {2'd3, 4'b0111});
        ifc.req_n = 4'b0101;
        tick(3);
        chk("hid_wait", ifc.gnt_n, 4'b0111);
        ifc.frame_n = 1; ifc.irdy_n = 1;
        tick(1);
        ifc.frame_n = 0; ifc.irdy_n = 0;
        tick(2);
        chk("hid_busy_gap", ifc.gnt_n, 4'hF);

        ifc.req_n = 4'b0111; ifc.frame_n = 1; ifc.irdy_n = 1;
        tick(3);
        ifc.frame_n = 0; ifc.irdy_n = 0;
        tick(1);
        chk("pre_rst_owner", {ifc.owner, ifc.gnt_n}, {2'd3, 4'b0111});
        rst_n = 0;
        tick(1);
        chk("mid_rst", {ifc.bus_idle, ifc.owner, ifc.gnt_n}, {1'b1, 2'(PARK), 4'hF});
        rst_n = 1; ifc.frame_n = 1; ifc.irdy_n = 1; ifc.req_n = 4'hF;

        txn_left = 0;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            rst_n = $urandom_range(299) != 0;
            if ($urandom_range(3) == 0) ifc.req_n = 4'($urandom) | 4'($urandom);
            if (txn_left > 0) begin
                ifc.frame_n = txn_left == 1; ifc.irdy_n = $urandom_range(3) == 0 && txn_left > 1;
                txn_left--;
            end else if ($urandom_range(7) == 0) begin
                txn_left = $urandom_range(5, 1);
                ifc.frame_n = 0; ifc.irdy_n = 1;
            end else begin
                ifc.frame_n = 1; ifc.irdy_n = 1;
            end
        end
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
